// File: rtl/conv_pkg.sv
// Shared definitions for the conv window interface: geometry, producer FSM
// one-hot states and the conv engine's idle/m_1..m_5 state encodings.
package conv_pkg;

  localparam int DATA_W = 9;
  localparam int K      = 5;
  localparam int ROW_W  = K * DATA_W;

  localparam logic [2:0] S_STREAM = 3'b001;
  localparam logic [2:0] S_HOLD   = 3'b010;
  localparam logic [2:0] S_DONE   = 3'b100;

  typedef enum logic [2:0] {
    GEN_STREAM = S_STREAM,
    GEN_HOLD   = S_HOLD,
    GEN_DONE   = S_DONE
  } gen_state_e;

  // Consumer-side (conv) row sequencing, one-hot like the producer.
  typedef enum logic [5:0] {
    CONV_IDLE = 6'b000001,
    CONV_M_1  = 6'b000010,
    CONV_M_2  = 6'b000100,
    CONV_M_3  = 6'b001000,
    CONV_M_4  = 6'b010000,
    CONV_M_5  = 6'b100000
  } conv_state_e;

endpackage

// File: rtl/conv_line_buf.sv
// One image line of delay: dout is the pixel pushed DEPTH enables ago.
// Storage is never reset; stale contents only reach row-straddling windows.
module conv_line_buf #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  import conv_pkg::*;

  logic [WIDTH-1:0] sr_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      sr_reg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_reg[i] <= sr_reg[i-1];
      end
    end
  end

  assign dout = sr_reg[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream -> 5x5 windows held on x_m_1..x_m_5 until conv consumes them.
// Optional HOLD watchdog enabled by defining CONV_WDOG_EN.
module conv_window_gen #(
  parameter int DATA_W   = 9,
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int WDOG_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          pix_valid,
  input  logic [DATA_W-1:0]             pix_data,
  output logic                          pix_ready,
  output logic                          x_valid,
  output logic [conv_pkg::K*DATA_W-1:0] x_m_1,
  output logic [conv_pkg::K*DATA_W-1:0] x_m_2,
  output logic [conv_pkg::K*DATA_W-1:0] x_m_3,
  output logic [conv_pkg::K*DATA_W-1:0] x_m_4,
  output logic [conv_pkg::K*DATA_W-1:0] x_m_5,
  input  logic                          conv_valid,
  output logic                          frame_done,
  output logic                          wdog_err
);
  import conv_pkg::*;

  localparam int RW = K * DATA_W;
  localparam int CW = $clog2(IMG_W);
  localparam int HW = $clog2(IMG_H);

  genvar gi;

  generate
    if (IMG_W < K || IMG_H < K || WDOG_CYC < 1) begin : g_cfg_check
      $error("conv_window_gen: IMG_W/IMG_H must be >= 5 and WDOG_CYC >= 1");
    end
  endgenerate

  gen_state_e               state_reg, state_next;
  logic                     pix_ready_reg, x_valid_reg, frame_done_reg, last_reg;
  logic [CW-1:0]            col_cnt_reg;
  logic [HW-1:0]            row_cnt_reg;
  logic [K-1:0][RW-1:0]     win_reg;
  logic [K-2:0][DATA_W-1:0] tap;
  logic [K-1:0][DATA_W-1:0] col_in;
  logic                     accept, win_ok, is_last, col_wrap, row_wrap, wdog_timeout;

  assign accept   = pix_valid && pix_ready_reg;
  assign col_wrap = (col_cnt_reg == CW'(IMG_W - 1));
  assign row_wrap = (row_cnt_reg == HW'(IMG_H - 1));
  assign win_ok   = (row_cnt_reg >= HW'(K - 1)) && (col_cnt_reg >= CW'(K - 1));
  assign is_last  = col_wrap && row_wrap;

  // Cascaded line buffers: tap[gi] is the pixel gi+1 rows above the incoming one.
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_lb
      logic [DATA_W-1:0] lb_din;
      if (gi == 0) begin : g_head
        assign lb_din = pix_data;
      end else begin : g_chain
        assign lb_din = tap[gi-1];
      end
      conv_line_buf #(
        .DEPTH (IMG_W),
        .WIDTH (DATA_W)
      ) u_lb (
        .clk  (clk),
        .en   (accept),
        .din  (lb_din),
        .dout (tap[gi])
      );
    end
  endgenerate

  // Window row 0 is the oldest line, row K-1 the live pixel.
  always_comb begin
    col_in[K-1] = pix_data;
    for (int r = 0; r < K - 1; r++) begin
      col_in[r] = tap[K-2-r];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      GEN_STREAM: if (accept && win_ok) state_next = GEN_HOLD;
      GEN_HOLD:   if (conv_valid || wdog_timeout) state_next = last_reg ? GEN_DONE : GEN_STREAM;
      GEN_DONE:   state_next = GEN_STREAM;
      default:    state_next = GEN_STREAM;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= GEN_STREAM;
      pix_ready_reg  <= 1'b0;
      x_valid_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      last_reg       <= 1'b0;
      col_cnt_reg    <= '0;
      row_cnt_reg    <= '0;
      win_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      pix_ready_reg  <= (state_next == GEN_STREAM);
      x_valid_reg    <= (state_next == GEN_HOLD);
      frame_done_reg <= (state_next == GEN_DONE);
      if (accept) begin
        for (int r = 0; r < K; r++) begin
          win_reg[r] <= {col_in[r], win_reg[r][RW-1:DATA_W]};
        end
        if (col_wrap) begin
          col_cnt_reg <= '0;
          row_cnt_reg <= row_wrap ? '0 : row_cnt_reg + 1'b1;
        end else begin
          col_cnt_reg <= col_cnt_reg + 1'b1;
        end
        if (win_ok) last_reg <= is_last;
      end
    end
  end

`ifdef CONV_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);

  logic [WW-1:0] wdog_cnt_reg;
  logic          wdog_err_reg;

  // Counts HOLD cycles; the window is abandoned on the WDOG_CYC-th one.
  assign wdog_timeout = (state_reg == GEN_HOLD) && !conv_valid &&
                        (wdog_cnt_reg == WW'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wdog_cnt_reg <= '0;
      wdog_err_reg <= 1'b0;
    end else begin
      wdog_cnt_reg <= (state_reg == GEN_HOLD) ? wdog_cnt_reg + 1'b1 : '0;
      if (wdog_timeout) wdog_err_reg <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_reg;
`else
  assign wdog_timeout = 1'b0;
  assign wdog_err     = 1'b0;
`endif

  assign pix_ready  = pix_ready_reg;
  assign x_valid    = x_valid_reg;
  assign frame_done = frame_done_reg;
  assign x_m_1      = win_reg[0];
  assign x_m_2      = win_reg[1];
  assign x_m_3      = win_reg[2];
  assign x_m_4      = win_reg[3];
  assign x_m_5      = win_reg[4];

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x8 frame with pix_data = row*8 + col.
module tb_conv_window_gen;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pix_valid = 1'b0;
  logic [8:0]  pix_data = '0;
  logic        pix_ready;
  logic        x_valid;
  logic [44:0] x_m_1, x_m_2, x_m_3, x_m_4, x_m_5;
  logic        conv_valid = 1'b0;
  logic        frame_done;
  logic        wdog_err;

  int n_cmp = 0;
  int n_bad = 0;
  int pix_idx = 0;
  int last_acc = -1;
  int hold_cycles = 0;
  bit auto_conv = 1'b0;
  int conv_delay = 3;

  conv_window_gen #(
    .DATA_W   (9),
    .IMG_W    (8),
    .IMG_H    (8),
    .WDOG_CYC (64)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .x_valid    (x_valid),
    .x_m_1      (x_m_1),
    .x_m_2      (x_m_2),
    .x_m_3      (x_m_3),
    .x_m_4      (x_m_4),
    .x_m_5      (x_m_5),
    .conv_valid (conv_valid),
    .frame_done (frame_done),
    .wdog_err   (wdog_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // Packed row of five consecutive pixel values, col 0 in the LSBs.
  function automatic logic [44:0] exp_row(input int first);
    logic [44:0] v;
    v = '0;
    for (int c = 0; c < 5; c++) v[c*9 +: 9] = 9'(first + c);
    return v;
  endfunction

  // One clock: pixel source advances on acceptance, conv model answers after conv_delay.
  task automatic tick();
    bit acc;
    acc = pix_valid && pix_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      last_acc = pix_idx;
      pix_idx++;
    end
    pix_data = 9'(pix_idx % 64);
    if (x_valid) hold_cycles++;
    else hold_cycles = 0;
    conv_valid = auto_conv && x_valid && (hold_cycles == conv_delay + 1);
  endtask

  task automatic wait_window(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(x_valid && hold_cycles == 1) && n < 300);
    n_cmp++;
    if (!(x_valid && hold_cycles == 1)) begin
      n_bad++;
      $display("FAIL %s_timeout: x_valid=%b after %0d cycles, required 1", name, x_valid, n);
    end else begin
      $display("window %s: last accepted pixel %0d", name, last_acc);
    end
  endtask

  task automatic reset_dut();
    rstn = 1'b0;
    pix_valid = 1'b0;
    conv_valid = 1'b0;
    auto_conv = 1'b0;
    pix_idx = 0;
    pix_data = '0;
    last_acc = -1;
    hold_cycles = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL rst_x_valid: got %b required 0", x_valid); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pix_ready: got %b required 0", pix_ready); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
    n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL rst_wdog_err: got %b required 0", wdog_err); end
    n_cmp++; if (x_m_1 !== 45'd0) begin n_bad++; $display("FAIL rst_x_m_1: got %h required 0", x_m_1); end
    n_cmp++; if (x_m_5 !== 45'd0) begin n_bad++; $display("FAIL rst_x_m_5: got %h required 0", x_m_5); end
    rstn = 1'b1;
    tick();
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL rst_release_ready: got %b required 1", pix_ready); end
    n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release_x_valid: got %b required 0", x_valid); end
  endtask

  task automatic test_first_window();
    pix_valid = 1'b1;
    auto_conv = 1'b0;
    wait_window("first");
    n_cmp++; if (last_acc != 36) begin n_bad++; $display("FAIL first_latency: rose after pixel %0d, required 36", last_acc); end
    n_cmp++; if (x_m_1 !== exp_row(0)) begin n_bad++; $display("FAIL first_x_m_1: got %h required %h", x_m_1, exp_row(0)); end
    n_cmp++; if (x_m_2 !== exp_row(8)) begin n_bad++; $display("FAIL first_x_m_2: got %h required %h", x_m_2, exp_row(8)); end
    n_cmp++; if (x_m_3 !== exp_row(16)) begin n_bad++; $display("FAIL first_x_m_3: got %h required %h", x_m_3, exp_row(16)); end
    n_cmp++; if (x_m_4 !== exp_row(24)) begin n_bad++; $display("FAIL first_x_m_4: got %h required %h", x_m_4, exp_row(24)); end
    n_cmp++; if (x_m_5 !== exp_row(32)) begin n_bad++; $display("FAIL first_x_m_5: got %h required %h", x_m_5, exp_row(32)); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL first_pix_ready: got %b required 0", pix_ready); end
  endtask

  task automatic test_hold_stable();
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (x_m_1 !== exp_row(0) || x_m_2 !== exp_row(8) || x_m_3 !== exp_row(16) ||
          x_m_4 !== exp_row(24) || x_m_5 !== exp_row(32) || pix_ready !== 1'b0 || x_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_stable[%0d]: x_m_1=%h x_m_5=%h ready=%b valid=%b, required window 0 held, ready 0, valid 1",
                 i, x_m_1, x_m_5, pix_ready, x_valid);
      end
    end
    conv_valid = 1'b1;
    tick();
    n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_x_valid: got %b required 0", x_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL hold_release_ready: got %b required 1", pix_ready); end
    wait_window("second");
    n_cmp++; if (last_acc != 37) begin n_bad++; $display("FAIL second_pixel: got %0d required 37", last_acc); end
    n_cmp++; if (x_m_1 !== exp_row(1)) begin n_bad++; $display("FAIL second_x_m_1: got %h required %h", x_m_1, exp_row(1)); end
    n_cmp++; if (x_m_5 !== exp_row(33)) begin n_bad++; $display("FAIL second_x_m_5: got %h required %h", x_m_5, exp_row(33)); end
  endtask

  task automatic test_row_straddle();
    auto_conv = 1'b1;
    conv_delay = 3;
    wait_window("p38");
    n_cmp++; if (last_acc != 38) begin n_bad++; $display("FAIL straddle_p38: got %0d required 38", last_acc); end
    wait_window("p39");
    n_cmp++; if (last_acc != 39) begin n_bad++; $display("FAIL straddle_p39: got %0d required 39", last_acc); end
    wait_window("p44");
    n_cmp++; if (last_acc != 44) begin n_bad++; $display("FAIL straddle_next: got %0d required 44", last_acc); end
    n_cmp++; if (x_m_1 !== exp_row(8)) begin n_bad++; $display("FAIL straddle_x_m_1: got %h required %h", x_m_1, exp_row(8)); end
    n_cmp++; if (x_m_5 !== exp_row(40)) begin n_bad++; $display("FAIL straddle_x_m_5: got %h required %h", x_m_5, exp_row(40)); end
  endtask

  task automatic test_full_frame();
    int win_cnt;
    int done_cnt;
    int n;
    logic [44:0] last_x5;
    bit seen_done;
    reset_dut();
    pix_valid = 1'b1;
    auto_conv = 1'b1;
    conv_delay = 3;
    win_cnt = 0;
    done_cnt = 0;
    last_x5 = '0;
    seen_done = 1'b0;
    n = 0;
    while (!seen_done && n < 2000) begin
      tick();
      n++;
      if (x_valid && hold_cycles == 1) begin
        win_cnt++;
        last_x5 = x_m_5;
        $display("window frame#%0d: last accepted pixel %0d", win_cnt, last_acc);
      end
      if (frame_done) begin
        done_cnt++;
        seen_done = 1'b1;
        n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL done_pix_ready: got %b required 0", pix_ready); end
      end
    end
    n_cmp++; if (!seen_done) begin n_bad++; $display("FAIL frame_done_timeout: got 0 pulses in %0d cycles, required 1", n); end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done) done_cnt++;
    end
    n_cmp++; if (win_cnt != 16) begin n_bad++; $display("FAIL frame_windows: got %0d required 16", win_cnt); end
    n_cmp++; if (last_x5 !== exp_row(59)) begin n_bad++; $display("FAIL frame_last_x_m_5: got %h required %h", last_x5, exp_row(59)); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL frame_done_pulses: got %0d required 1", done_cnt); end
    wait_window("frame2_first");
    n_cmp++; if (last_acc != 100) begin n_bad++; $display("FAIL frame2_pixel: got %0d required 100", last_acc); end
    n_cmp++; if (x_m_1 !== exp_row(0)) begin n_bad++; $display("FAIL frame2_x_m_1: got %h required %h", x_m_1, exp_row(0)); end
    n_cmp++; if (x_m_5 !== exp_row(32)) begin n_bad++; $display("FAIL frame2_x_m_5: got %h required %h", x_m_5, exp_row(32)); end
  endtask

  task automatic test_reset_in_hold();
    auto_conv = 1'b0;
    conv_valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_x_valid: got %b required 0", x_valid); end
    n_cmp++; if (x_m_1 !== 45'd0) begin n_bad++; $display("FAIL midrst_x_m_1: got %h required 0", x_m_1); end
    n_cmp++; if (x_m_5 !== 45'd0) begin n_bad++; $display("FAIL midrst_x_m_5: got %h required 0", x_m_5); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_pix_ready: got %b required 0", pix_ready); end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    pix_idx = 0;
    pix_data = '0;
    last_acc = -1;
    hold_cycles = 0;
    pix_valid = 1'b1;
    auto_conv = 1'b1;
    wait_window("restart");
    n_cmp++; if (last_acc != 36) begin n_bad++; $display("FAIL restart_pixel: got %0d required 36", last_acc); end
    n_cmp++; if (x_m_1 !== exp_row(0)) begin n_bad++; $display("FAIL restart_x_m_1: got %h required %h", x_m_1, exp_row(0)); end
    n_cmp++; if (x_m_5 !== exp_row(32)) begin n_bad++; $display("FAIL restart_x_m_5: got %h required %h", x_m_5, exp_row(32)); end
  endtask

  task automatic test_watchdog();
    reset_dut();
    pix_valid = 1'b1;
    auto_conv = 1'b0;
    wait_window("wdog");
    repeat (63) tick();
    n_cmp++; if (x_valid !== 1'b1) begin n_bad++; $display("FAIL wdog_hold64_x_valid: got %b required 1", x_valid); end
    n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL wdog_hold64_err: got %b required 0", wdog_err); end
    tick();
`ifdef CONV_WDOG_EN
    n_cmp++; if (wdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_err_set: got %b required 1", wdog_err); end
    n_cmp++; if (x_valid !== 1'b0) begin n_bad++; $display("FAIL wdog_x_valid_drop: got %b required 0", x_valid); end
    n_cmp++; if (pix_ready !== 1'b1) begin n_bad++; $display("FAIL wdog_pix_ready: got %b required 1", pix_ready); end
    repeat (3) tick();
    n_cmp++; if (wdog_err !== 1'b1) begin n_bad++; $display("FAIL wdog_sticky: got %b required 1", wdog_err); end
`else
    n_cmp++; if (x_valid !== 1'b1) begin n_bad++; $display("FAIL nowdog_x_valid: got %b required 1", x_valid); end
    n_cmp++; if (wdog_err !== 1'b0) begin n_bad++; $display("FAIL nowdog_err: got %b required 0", wdog_err); end
    n_cmp++; if (pix_ready !== 1'b0) begin n_bad++; $display("FAIL nowdog_pix_ready: got %b required 0", pix_ready); end
`endif
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_hold_stable();
    test_row_straddle();
    test_full_frame();
    test_reset_in_hold();
    test_watchdog();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
